// File: rtl/zbk_bitmanip_pipe.sv
// Zbkb bit-manipulation execute unit with an elastic valid/ready pipeline.
// Define ZBKX_EN to add the XPERM4/XPERM8 crossbar ops (12/13).
module zbk_bitmanip_pipe #(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic             busy
);

   localparam int SH = $clog2(XLEN);
   localparam int PW = XLEN + TAG_W + 1;
   localparam logic [SH:0] XLEN_W = (SH+1)'(XLEN);

   localparam logic [3:0] OP_ROR    = 4'd0;
   localparam logic [3:0] OP_ROL    = 4'd1;
   localparam logic [3:0] OP_RORI   = 4'd2;
   localparam logic [3:0] OP_ANDN   = 4'd3;
   localparam logic [3:0] OP_ORN    = 4'd4;
   localparam logic [3:0] OP_XNOR   = 4'd5;
   localparam logic [3:0] OP_PACK   = 4'd6;
   localparam logic [3:0] OP_PACKH  = 4'd7;
   localparam logic [3:0] OP_BREV8  = 4'd8;
   localparam logic [3:0] OP_REV8   = 4'd9;
   localparam logic [3:0] OP_ZIP    = 4'd10;
   localparam logic [3:0] OP_UNZIP  = 4'd11;
`ifdef ZBKX_EN
   localparam logic [3:0] OP_XPERM4 = 4'd12;
   localparam logic [3:0] OP_XPERM8 = 4'd13;
`endif

   logic [SH-1:0]   shamt;
   logic [XLEN-1:0] ror_res;
   logic [XLEN-1:0] rol_res;
   logic [XLEN-1:0] res;
   logic            ill;

   // A shift by XLEN yields zero, so amount 0 passes rs1 through unchanged.
   assign shamt   = in_rs2[SH-1:0];
   assign ror_res = (in_rs1 >> shamt) | (in_rs1 << (XLEN_W - {1'b0, shamt}));
   assign rol_res = (in_rs1 << shamt) | (in_rs1 >> (XLEN_W - {1'b0, shamt}));

   always_comb begin
      res = '0;
      ill = 1'b0;
      case (in_op)
         OP_ROR, OP_RORI: res = ror_res;
         OP_ROL:          res = rol_res;
         OP_ANDN:         res = in_rs1 & ~in_rs2;
         OP_ORN:          res = in_rs1 | ~in_rs2;
         OP_XNOR:         res = ~(in_rs1 ^ in_rs2);
         OP_PACK:         res = {in_rs2[XLEN/2-1:0], in_rs1[XLEN/2-1:0]};
         OP_PACKH:        res[15:0] = {in_rs2[7:0], in_rs1[7:0]};
         OP_BREV8: begin
            for (int b = 0; b < XLEN/8; b++)
               for (int k = 0; k < 8; k++)
                  res[8*b+k] = in_rs1[8*b+7-k];
         end
         OP_REV8: begin
            for (int b = 0; b < XLEN/8; b++)
               res[8*b +: 8] = in_rs1[XLEN-8-8*b +: 8];
         end
         OP_ZIP: begin
            if (XLEN == 32) begin
               for (int i = 0; i < 16; i++) begin
                  res[2*i]   = in_rs1[i];
                  res[2*i+1] = in_rs1[i+16];
               end
            end else begin
               ill = 1'b1;
            end
         end
         OP_UNZIP: begin
            if (XLEN == 32) begin
               for (int i = 0; i < 16; i++) begin
                  res[i]    = in_rs1[2*i];
                  res[i+16] = in_rs1[2*i+1];
               end
            end else begin
               ill = 1'b1;
            end
         end
`ifdef ZBKX_EN
         OP_XPERM4: begin
            for (int i = 0; i < XLEN/4; i++)
               if (int'(in_rs2[4*i +: 4]) < XLEN/4)
                  res[4*i +: 4] = in_rs1[4*in_rs2[4*i +: 4] +: 4];
         end
         OP_XPERM8: begin
            for (int i = 0; i < XLEN/8; i++)
               if (int'(in_rs2[8*i +: 8]) < XLEN/8)
                  res[8*i +: 8] = in_rs1[8*in_rs2[8*i +: 8] +: 8];
         end
`endif
         default: ill = 1'b1;
      endcase
   end

   logic [PIPE_STAGES-1:0] valid_q;
   logic [PW-1:0]          data_q [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] valid_d;
   logic [PW-1:0]          data_d [PIPE_STAGES];
   logic [PIPE_STAGES:0]   stage_rdy;

   // A stage may load when empty or when its occupant moves on; this lets bubbles collapse.
   assign stage_rdy[PIPE_STAGES] = out_ready;

   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      assign stage_rdy[k] = ~valid_q[k] | stage_rdy[k+1];
      if (k == 0) begin : g_first
         assign valid_d[k] = in_valid;
         assign data_d[k]  = {ill, in_tag, res};
      end else begin : g_next
         assign valid_d[k] = valid_q[k-1];
         assign data_d[k]  = data_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            valid_q[k] <= 1'b0;
            data_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            if (stage_rdy[k]) begin
               valid_q[k] <= valid_d[k];
               if (valid_d[k]) data_q[k] <= data_d[k];
            end
         end
      end
   end

   assign in_ready  = stage_rdy[0];
   assign out_valid = valid_q[PIPE_STAGES-1];
   assign {out_illegal, out_tag, out_result} = data_q[PIPE_STAGES-1];
   assign busy      = |valid_q;

endmodule
